// File: rtl/phy_pkg.sv
// Shared definitions for the PHY lane schedulers (transmit arbiter and its
// receive-side counterpart).
package phy_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CH = 4;
  localparam logic [DATA_W-1:0] IDLE_SYM = 8'hBC;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } phy_state_e;

endpackage : phy_pkg

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: finds the first requester at or after ptr,
// wrapping modulo 4. Purely combinational so both schedulers can share it.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick4

// File: rtl/phy_rr_arbiter.sv
// Transmit-side lane scheduler: emits INIT_SYMS idle sync symbols after
// reset, then round-robins four show-ahead FIFOs onto one byte lane,
// popping at most one byte per cycle and honouring almost_full.
//
// state | meaning
// ------+-------------------------------------------------------------
// SYNC  | post-reset idle run; counts INIT_SYMS cycles, never pops
// RUN   | arbitration enabled; pops one byte per cycle when allowed
module phy_rr_arbiter
  import phy_pkg::*;
#(
  parameter int unsigned INIT_SYMS = 4
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              almost_full,
  output logic [NUM_CH-1:0] pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        grant_id,
  output logic              active
);

  phy_state_e        state_q, state_d;
  logic [3:0]        sync_cnt_q, sync_cnt_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic [1:0]        grant_id_q, grant_id_d;
  logic              active_q, active_d;

  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              grant;
  logic [DATA_W-1:0] sel_data;

  rr_pick4 u_pick (
    .req   (~fifo_empty),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A grant needs RUN, no backpressure, a candidate, and no reset this cycle.
  assign grant = (state_q == RUN) && !almost_full && pick_found && !reset;

  // Pop strobe and head-byte mux for the picked channel.
  always_comb begin
    pop = '0;
    if (grant) pop[pick_idx] = 1'b1;
    case (pick_idx)
      2'd0:    sel_data = data_in_0;
      2'd1:    sel_data = data_in_1;
      2'd2:    sel_data = data_in_2;
      default: sel_data = data_in_3;
    endcase
  end

  // Next-state and next-output computation; idle symbol unless a byte is granted.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    data_out_d = IDLE_SYM;
    valid_d    = 1'b0;
    grant_id_d = grant_id_q;
    active_d   = active_q;
    case (state_q)
      SYNC: begin
        sync_cnt_d = sync_cnt_q + 4'd1;
        if (sync_cnt_q == 4'(INIT_SYMS - 1)) begin
          state_d  = RUN;
          active_d = 1'b1;
        end
      end
      RUN: begin
        active_d = 1'b1;
        if (grant) begin
          data_out_d = sel_data;
          valid_d    = 1'b1;
          grant_id_d = pick_idx;
          rr_ptr_d   = pick_idx + 2'd1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q    <= SYNC;
      sync_cnt_q <= '0;
      rr_ptr_q   <= '0;
      data_out_q <= IDLE_SYM;
      valid_q    <= 1'b0;
      grant_id_q <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      grant_id_q <= grant_id_d;
      active_q   <= active_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;

endmodule : phy_rr_arbiter

// File: tb/tb_phy_rr_arbiter.sv
// Bench for phy_rr_arbiter: scenario tasks plus a randomized run, all
// compared against a cycle-level behavioural model of the lane scheduler.
module tb_phy_rr_arbiter;

  localparam int INIT_SYMS = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_f = 1'b0;
  logic       reset;
  logic [3:0] fifo_empty;
  logic [7:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic       almost_full;
  logic [3:0] pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant_id;
  logic       active;

  int checks = 0;
  int errors = 0;

  phy_rr_arbiter #(.INIT_SYMS(INIT_SYMS)) dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .data_in_0   (data_in_0),
    .data_in_1   (data_in_1),
    .data_in_2   (data_in_2),
    .data_in_3   (data_in_3),
    .almost_full (almost_full),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .grant_id    (grant_id),
    .active      (active)
  );

  always #5 clk_f = ~clk_f;

  // Behavioural model state
  int         m_ptr = 0;
  int         m_sync = 0;
  bit         m_active = 0;
  logic [7:0] m_data = IDLE;
  bit         m_valid = 0;
  int         m_gid = 0;
  int         m_cand = -1;
  logic [3:0] m_pop = 4'b0;
  logic [7:0] din [4];

  function automatic int find_cand(input logic [3:0] fe, input int ptr);
    for (int k = 0; k < 4; k++)
      if (!fe[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Drive one cycle of inputs (just after a rising edge) and predict pop.
  task automatic apply(input logic rst, input logic [3:0] fe, input logic af,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    reset = rst; fifo_empty = fe; almost_full = af;
    data_in_0 = b0; data_in_1 = b1; data_in_2 = b2; data_in_3 = b3;
    din[0] = b0; din[1] = b1; din[2] = b2; din[3] = b3;
    m_cand = (rst || !m_active || af) ? -1 : find_cand(fe, m_ptr);
    m_pop  = (m_cand < 0) ? 4'b0000 : 4'(1 << m_cand);
    #2;
  endtask

  // Advance one clock edge and update the model's registered outputs.
  task automatic tick();
    @(posedge clk_f);
    if (reset) begin
      m_ptr = 0; m_sync = 0; m_active = 0; m_data = IDLE; m_valid = 0; m_gid = 0;
    end else if (!m_active) begin
      m_sync++;
      if (m_sync == INIT_SYMS) m_active = 1;
      m_data = IDLE; m_valid = 0;
    end else if (m_cand >= 0) begin
      m_data = din[m_cand]; m_valid = 1; m_gid = m_cand; m_ptr = (m_cand + 1) % 4;
    end else begin
      m_data = IDLE; m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    int rise_at;
    apply(1, 4'hF, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++;
    if (pop !== 4'b0000) begin errors++; $display("FAIL rst_pop got %b exp 0000", pop); end
    tick();
    apply(1, 4'hF, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checks++;
    if (data_out !== IDLE || valid_out !== 1'b0 || grant_id !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL rst_regs got d=%h v=%b g=%0d a=%b exp d=bc v=0 g=0 a=0",
               data_out, valid_out, grant_id, active);
    end
    rise_at = -1;
    for (int i = 1; i <= 6; i++) begin
      apply(0, 4'hF, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      checks++;
      if (pop !== 4'b0000) begin errors++; $display("FAIL sync_pop cyc %0d got %b exp 0000", i, pop); end
      tick();
      checks++;
      if (data_out !== IDLE || valid_out !== 1'b0) begin
        errors++; $display("FAIL sync_lane cyc %0d got d=%h v=%b exp d=bc v=0", i, data_out, valid_out);
      end
      if (active === 1'b1 && rise_at < 0) rise_at = i;
    end
    checks++;
    if (rise_at != INIT_SYMS) begin
      errors++; $display("FAIL active_rise got cycle %0d exp %0d", rise_at, INIT_SYMS);
    end
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 8; i++) begin
      apply(0, 4'h0, 0, 8'h10, 8'h11, 8'h12, 8'h13);
      checks++;
      if (pop !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL rot_pop cyc %0d got %b exp %b", i, pop, 4'(1 << (i % 4)));
      end
      tick();
      checks++;
      if (data_out !== 8'(8'h10 + i % 4) || valid_out !== 1'b1 || grant_id !== 2'(i % 4)) begin
        errors++;
        $display("FAIL rot_lane cyc %0d got d=%h v=%b g=%0d exp d=%h v=1 g=%0d",
                 i, data_out, valid_out, grant_id, 8'(8'h10 + i % 4), i % 4);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      apply(0, 4'b1011, 0, 8'($urandom), 8'($urandom), b, 8'($urandom));
      checks++;
      if (pop !== 4'b0100) begin errors++; $display("FAIL single_pop cyc %0d got %b exp 0100", i, pop); end
      tick();
      checks++;
      if (data_out !== b || valid_out !== 1'b1 || grant_id !== 2'd2) begin
        errors++;
        $display("FAIL single_lane cyc %0d got d=%h v=%b g=%0d exp d=%h v=1 g=2",
                 i, data_out, valid_out, grant_id, b);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] afpat;
    int last;
    afpat = 8'b0001_1100;
    last  = -1;
    for (int i = 0; i < 8; i++) begin
      apply(0, 4'b0101, afpat[i], 8'hA0, 8'hA1, 8'hA2, 8'hA3);
      checks++;
      if (pop !== m_pop) begin
        errors++; $display("FAIL bp_pop cyc %0d got %b exp %b", i, pop, m_pop);
      end
      tick();
      checks++;
      if (data_out !== m_data || valid_out !== m_valid || grant_id !== 2'(m_gid)) begin
        errors++;
        $display("FAIL bp_lane cyc %0d got d=%h v=%b g=%0d exp d=%h v=%b g=%0d",
                 i, data_out, valid_out, grant_id, m_data, m_valid, m_gid);
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (int'(grant_id) == last) begin
          errors++; $display("FAIL bp_alternate cyc %0d got g=%0d exp other than %0d", i, grant_id, last);
        end
        last = int'(grant_id);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(0, 4'b1101, 0, 8'h00, 8'h5A, 8'h00, 8'h00);
    checks++;
    if (pop !== 4'b0010) begin errors++; $display("FAIL mid_pre_pop got %b exp 0010", pop); end
    tick();
    apply(1, 4'b1101, 0, 8'h00, 8'h5B, 8'h00, 8'h00);
    checks++;
    if (pop !== 4'b0000) begin errors++; $display("FAIL mid_rst_pop got %b exp 0000", pop); end
    tick();
    checks++;
    if (valid_out !== 1'b0 || active !== 1'b0 || data_out !== IDLE) begin
      errors++;
      $display("FAIL mid_rst_regs got d=%h v=%b a=%b exp d=bc v=0 a=0", data_out, valid_out, active);
    end
    for (int i = 0; i < INIT_SYMS; i++) begin
      apply(0, 4'b0011, 0, 8'h30, 8'h31, 8'h32, 8'h33);
      checks++;
      if (pop !== 4'b0000) begin errors++; $display("FAIL resync_pop cyc %0d got %b exp 0000", i, pop); end
      tick();
    end
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL resync_active got %b exp 1", active); end
    apply(0, 4'b0011, 0, 8'h30, 8'h31, 8'h32, 8'h33);
    checks++;
    if (pop !== 4'b0100) begin errors++; $display("FAIL resync_first_pop got %b exp 0100", pop); end
    tick();
    checks++;
    if (data_out !== 8'h32 || grant_id !== 2'd2) begin
      errors++; $display("FAIL resync_first_lane got d=%h g=%0d exp d=32 g=2", data_out, grant_id);
    end
  endtask

  task automatic test_random();
    logic rst, af;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      af  = ($urandom_range(0, 9) < 3);
      apply(rst, 4'($urandom), af, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      checks++;
      if (pop !== m_pop) begin
        errors++; $display("FAIL rnd_pop cyc %0d got %b exp %b", i, pop, m_pop);
      end
      tick();
      checks++;
      if (data_out !== m_data || valid_out !== m_valid || grant_id !== 2'(m_gid) || active !== m_active) begin
        errors++;
        $display("FAIL rnd_lane cyc %0d got d=%h v=%b g=%0d a=%b exp d=%h v=%b g=%0d a=%b",
                 i, data_out, valid_out, grant_id, active, m_data, m_valid, m_gid, m_active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_phy_rr_arbiter
